// File: rtl/gamma_11bit.sv
// gamma_11bit: forward gamma expansion, 8-bit gamma-coded subpixel to 11-bit linear light.
// The result comes from 16-segment piecewise-linear interpolation over a 17-knot table.
// The pipeline is a fixed 3 stages with no stalls. Line and frame syncs travel with each pixel.
//
// Ports
//   clk        in   1   clock, all logic on posedge
//   rst        in   1   synchronous active-high reset
//   i_hs       in   1   line active
//   i_vs       in   1   frame active
//   gamma_in   in   8   gamma-coded pixel
//   gamma_out  out  11  linear pixel, 3 cycles after gamma_in
//   o_hs/o_vs  out  1   i_hs/i_vs delayed 3 cycles
//   lut_we     in   1   knot write strobe             (GAMMA_LUT_PROG_EN)
//   lut_addr   in   5   knot index 0..16              (GAMMA_LUT_PROG_EN)
//   lut_wdata  in   11  knot value                    (GAMMA_LUT_PROG_EN)
//   lut_err    out  1   sticky rejected-write flag    (GAMMA_LUT_PROG_EN)
//
// Macro GAMMA_LUT_PROG_EN makes the knot table a writable register file that is reloaded
// on reset. When the macro is undefined, the table is a constant ROM of the default curve.

module gamma_11bit #(
  parameter int KNOT_W = 11,
  parameter int SEG_B  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_hs,
  input  logic              i_vs,
  input  logic [7:0]        gamma_in,
  output logic [KNOT_W-1:0] gamma_out,
  output logic              o_hs,
  output logic              o_vs
`ifdef GAMMA_LUT_PROG_EN
  ,
  input  logic              lut_we,
  input  logic [4:0]        lut_addr,
  input  logic [KNOT_W-1:0] lut_wdata,
  output logic              lut_err
`endif
);

  localparam int FRAC_B  = 8 - SEG_B;
  localparam int NKNOT   = (1 << SEG_B) + 1;
  localparam int DELTA_W = KNOT_W + 1;
  localparam int PROD_W  = DELTA_W + FRAC_B;
  localparam int Y_W     = KNOT_W + 2;

  localparam logic [KNOT_W-1:0]        Y_MAX = '1;
  localparam logic signed [PROD_W-1:0] HALF  = PROD_W'(1 << (FRAC_B - 1));

  // Default curve: round(2047 * (16k/256)^2.2)
  function automatic logic [KNOT_W-1:0] default_knot(input int unsigned k);
    logic [KNOT_W-1:0] v;
    case (k)
      0:       v = KNOT_W'(0);
      1:       v = KNOT_W'(5);
      2:       v = KNOT_W'(21);
      3:       v = KNOT_W'(51);
      4:       v = KNOT_W'(97);
      5:       v = KNOT_W'(158);
      6:       v = KNOT_W'(237);
      7:       v = KNOT_W'(332);
      8:       v = KNOT_W'(446);
      9:       v = KNOT_W'(577);
      10:      v = KNOT_W'(728);
      11:      v = KNOT_W'(898);
      12:      v = KNOT_W'(1087);
      13:      v = KNOT_W'(1296);
      14:      v = KNOT_W'(1526);
      15:      v = KNOT_W'(1776);
      16:      v = KNOT_W'(2047);
      default: v = '0;
    endcase
    return v;
  endfunction

  logic [KNOT_W-1:0] knot [NKNOT];

`ifdef GAMMA_LUT_PROG_EN
  // Writes land only during vertical blanking, so no visible pixel mixes two tables.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NKNOT; k++) knot[k] <= default_knot(k);
      lut_err <= 1'b0;
    end else if (lut_we) begin
      if (!i_vs && (lut_addr < 5'(NKNOT))) knot[lut_addr] <= lut_wdata;
      else                                 lut_err        <= 1'b1;
    end
  end
`else
  always_comb begin
    for (int unsigned k = 0; k < NKNOT; k++) knot[k] = default_knot(k);
  end
`endif

  // Stage 1 registers
  logic [SEG_B-1:0]  s1_idx;
  logic [FRAC_B-1:0] s1_frac;
  logic              s1_blank, s1_hs, s1_vs;
  // Stage 2 registers
  logic [KNOT_W-1:0]        s2_lo;
  logic signed [PROD_W-1:0] s2_prod;
  logic                     s2_blank, s2_hs, s2_vs;

  logic [KNOT_W-1:0]         lo_c, hi_c;
  logic signed [DELTA_W-1:0] delta_c;
  logic signed [PROD_W-1:0]  prod_c, rnd_c;
  logic signed [Y_W-1:0]     y_c;
  logic [KNOT_W-1:0]         y_sat;

  always_comb begin
    lo_c    = knot[s1_idx];
    hi_c    = knot[{1'b0, s1_idx} + 1'b1];
    // The delta is signed so that programmed non-monotonic tables interpolate downward.
    delta_c = $signed({1'b0, hi_c}) - $signed({1'b0, lo_c});
    prod_c  = PROD_W'(delta_c) * PROD_W'($signed({1'b0, s1_frac}));
  end

  always_comb begin
    // Round half up: add half an LSB, then floor through an arithmetic shift.
    rnd_c = (s2_prod + HALF) >>> FRAC_B;
    y_c   = $signed({2'b00, s2_lo}) + Y_W'(rnd_c);
    if (y_c < 0)                            y_sat = '0;
    else if (y_c > $signed({2'b00, Y_MAX})) y_sat = Y_MAX;
    else                                    y_sat = y_c[KNOT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_idx    <= '0;
      s1_frac   <= '0;
      s1_blank  <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s2_lo     <= '0;
      s2_prod   <= '0;
      s2_blank  <= 1'b0;
      s2_hs     <= 1'b0;
      s2_vs     <= 1'b0;
      gamma_out <= '0;
      o_hs      <= 1'b0;
      o_vs      <= 1'b0;
    end else begin
      s1_idx    <= gamma_in[7:FRAC_B];
      s1_frac   <= gamma_in[FRAC_B-1:0];
      s1_blank  <= !(i_hs && i_vs);
      s1_hs     <= i_hs;
      s1_vs     <= i_vs;
      s2_lo     <= lo_c;
      s2_prod   <= prod_c;
      s2_blank  <= s1_blank;
      s2_hs     <= s1_hs;
      s2_vs     <= s1_vs;
      gamma_out <= s2_blank ? '0 : y_sat;
      o_hs      <= s2_hs;
      o_vs      <= s2_vs;
    end
  end

endmodule

// File: tb/tb_gamma_11bit.sv
// Self-checking bench for gamma_11bit.
// A behavioural model recomputes the default curve from the power law. It tracks the table,
// the error flag and the 3-cycle latency, and the bench compares the DUT against it every cycle.
// Directed checks pin the model with hand-computed values.

module tb_gamma_11bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_hs = 1'b0;
  logic        i_vs = 1'b0;
  logic [7:0]  gamma_in = 8'h00;
  logic [10:0] gamma_out;
  logic        o_hs, o_vs;
`ifdef GAMMA_LUT_PROG_EN
  logic        lut_we = 1'b0;
  logic [4:0]  lut_addr = 5'd0;
  logic [10:0] lut_wdata = 11'd0;
  logic        lut_err;
`endif

  gamma_11bit #(.KNOT_W(11), .SEG_B(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_hs      (i_hs),
    .i_vs      (i_vs),
    .gamma_in  (gamma_in),
    .gamma_out (gamma_out),
    .o_hs      (o_hs),
    .o_vs      (o_vs)
`ifdef GAMMA_LUT_PROG_EN
    ,
    .lut_we    (lut_we),
    .lut_addr  (lut_addr),
    .lut_wdata (lut_wdata),
    .lut_err   (lut_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // ---------------- behavioural model ----------------
  typedef struct {
    int v;
    bit h;
    bit s;
  } exp_t;

  int   mk_def [17];
  int   mk     [17];
  bit   m_err   = 1'b0;
  bit   started = 1'b0;
  exp_t pipe   [3];

  function automatic int model_pix(input int t [17], input int g, input bit h, input bit s);
    int idx, f, lo, p, r, y;
    if (!(h && s)) return 0;
    idx = g / 16;
    f   = g % 16;
    lo  = t[idx];
    p   = (t[idx + 1] - lo) * f + 8;
    r   = (p >= 0) ? p / 16 : -((15 - p) / 16);  // floor(p/16)
    y   = lo + r;
    if (y < 0) y = 0;
    else if (y > 2047) y = 2047;
    return y;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] <= '{v: 0, h: 1'b0, s: 1'b0};
      mk      <= mk_def;
      m_err   <= 1'b0;
      started <= 1'b1;
    end else begin
      e.v = model_pix(mk, int'(gamma_in), i_hs, i_vs);
      e.h = i_hs;
      e.s = i_vs;
      pipe[0] <= e;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
`ifdef GAMMA_LUT_PROG_EN
      if (lut_we) begin
        if (!i_vs && lut_addr <= 5'd16) mk[lut_addr] <= int'(lut_wdata);
        else                            m_err        <= 1'b1;
      end
`endif
    end
  end

  // ---------------- checking ----------------
  bit ramp_on  = 1'b0;
  int prev_out = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance n clocks, sampling 1 time unit after each edge and comparing against the model.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (started) begin
        check("model_gamma_out", int'(gamma_out), pipe[2].v);
        check("model_o_hs", int'(o_hs), int'(pipe[2].h));
        check("model_o_vs", int'(o_vs), int'(pipe[2].s));
`ifdef GAMMA_LUT_PROG_EN
        check("model_lut_err", int'(lut_err), int'(m_err));
`endif
        if (ramp_on) begin
          check("ramp_monotonic", (int'(gamma_out) >= prev_out) ? 1 : 0, 1);
          prev_out = int'(gamma_out);
        end
      end
    end
  endtask

`ifdef GAMMA_LUT_PROG_EN
  task automatic lut_write(input int a, input int d);
    lut_we    = 1'b1;
    lut_addr  = 5'(a);
    lut_wdata = 11'(d);
    cyc(1);
    lut_we    = 1'b0;
  endtask
`endif

  initial begin
    for (int k = 0; k < 17; k++)
      mk_def[k] = int'($floor(2047.0 * $pow(real'(k) / 16.0, 2.2) + 0.5));

    // Pin the model with hand-computed values.
    check("model_knot0", mk_def[0], 0);
    check("model_knot15", mk_def[15], 1776);
    check("model_knot16", mk_def[16], 2047);
    check("model_pix_FF", model_pix(mk_def, 255, 1'b1, 1'b1), 2030);
    check("model_pix_C8", model_pix(mk_def, 200, 1'b1, 1'b1), 1192);

    // Reset for two cycles.
    rst = 1'b1;
    cyc(2);
    check("reset_gamma_out", int'(gamma_out), 0);
    check("reset_o_hs", int'(o_hs), 0);
    check("reset_o_vs", int'(o_vs), 0);
`ifdef GAMMA_LUT_PROG_EN
    check("reset_lut_err", int'(lut_err), 0);
`endif
    rst = 1'b0; i_hs = 1'b1; i_vs = 1'b1; gamma_in = 8'h00;
    cyc(3);
    check("first_pix_00", int'(gamma_out), 0);
    check("first_o_hs", int'(o_hs), 1);
    check("first_o_vs", int'(o_vs), 1);

    gamma_in = 8'hF0; cyc(3); check("pix_F0", int'(gamma_out), 1776);
    gamma_in = 8'hFF; cyc(3); check("pix_FF", int'(gamma_out), 2030);
    gamma_in = 8'h80; cyc(3); check("pix_80_exact", int'(gamma_out), 446);

    // Full ramp: every cycle checked against the model, and the output must not decrease.
    gamma_in = 8'h00; cyc(3);
    prev_out = 0;
    ramp_on  = 1'b1;
    for (int i = 0; i < 256; i++) begin
      gamma_in = 8'(i);
      cyc(1);
    end
    cyc(3);
    ramp_on = 1'b0;

    // Line end: in-flight pixels finish, then blank output.
    gamma_in = 8'hC0; cyc(1);
    gamma_in = 8'hC8; cyc(1);
    i_hs = 1'b0; gamma_in = 8'hFF;
    cyc(2);
    check("hs_drop_last_pix", int'(gamma_out), 1192);
    check("hs_drop_o_hs_still", int'(o_hs), 1);
    cyc(1);
    check("hs_drop_blank_out", int'(gamma_out), 0);
    check("hs_drop_o_hs_fell", int'(o_hs), 0);

    // Reset in the middle of a line.
    i_hs = 1'b1; gamma_in = 8'h40; cyc(3);
    check("pix_40", int'(gamma_out), 97);
    rst = 1'b1; cyc(1);
    check("midline_rst_out", int'(gamma_out), 0);
    check("midline_rst_hs", int'(o_hs), 0);
    rst = 1'b0; cyc(2);
    check("post_rst_not_yet", int'(gamma_out), 0);
    cyc(1);
    check("post_rst_first", int'(gamma_out), 97);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 199) == 0);
      i_hs     = ($urandom_range(0, 3) != 0);
      i_vs     = ($urandom_range(0, 7) != 0);
      gamma_in = 8'($urandom);
`ifdef GAMMA_LUT_PROG_EN
      lut_we    = i_vs && ($urandom_range(0, 49) == 0);
      lut_addr  = 5'($urandom);
      lut_wdata = 11'($urandom);
`endif
      cyc(1);
    end
    rst = 1'b0; i_hs = 1'b1; i_vs = 1'b1;
`ifdef GAMMA_LUT_PROG_EN
    lut_we = 1'b0;
`endif
    cyc(3);

`ifdef GAMMA_LUT_PROG_EN
    // Linear table written during vertical blanking.
    rst = 1'b1; cyc(1); rst = 1'b0;
    i_vs = 1'b0;
    for (int k = 0; k < 17; k++) lut_write(k, 120 * k);
    check("prog_no_err", int'(lut_err), 0);
    i_vs = 1'b1; gamma_in = 8'h58; cyc(3);
    check("prog_pix_58", int'(gamma_out), 660);

    // A write while the frame is active is dropped and sets the sticky flag.
    lut_write(5, 999);
    check("prog_err_vs", int'(lut_err), 1);
    cyc(3);
    check("prog_table_kept", int'(gamma_out), 660);
    check("prog_err_sticky", int'(lut_err), 1);

    // Swapped knots give a negative slope: 100 + floor((-1500+8)/16) = 6.
    rst = 1'b1; cyc(1); rst = 1'b0;
    check("prog_err_cleared", int'(lut_err), 0);
    i_vs = 1'b0;
    lut_write(5, 100);
    lut_write(6, 0);
    i_vs = 1'b1; gamma_in = 8'h5F; cyc(3);
    check("prog_pix_5F_neg", int'(gamma_out), 6);

    // An out-of-range address is rejected even during blanking.
    i_vs = 1'b0;
    lut_write(20, 5);
    check("prog_err_addr", int'(lut_err), 1);
    i_vs = 1'b1; cyc(3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
